dot11_tx_iq_pacer: RTL and testbench

Downstream stage of dot11_tx. It consumes the 200 MHz-domain IQ stream (result_iq_valid/ready, result_i/q) into a FIFO. It prefills to a threshold, then emits one sample every CLK_DIV clocks (20 Msps at CLK_DIV=10) toward the DAC/RF interface. It flags underrun and signals end of packet after the FIFO drains.

---
 rtl/dot11_tx_pkg.sv | 24 ++
 rtl/iq_sync_fifo.sv | 73 +++++++
 rtl/dot11_tx_iq_pacer.sv | 142 ++++++++++++++
 tb/tb_dot11_tx_iq_pacer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot11_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dot11_tx_pkg
// Description : Shared constants and types for the dot11_tx IQ output path.
// Revision    : 1.0 - initial release
// ============================================================================
package dot11_tx_pkg;

    localparam int C_IQ_W      = 16;
    localparam int C_IQ_WORD_W = 2 * C_IQ_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_STREAM  = 2'd2
    } pacer_state_t;

    // Packed IQ word: I occupies the high half, Q the low half.
    function automatic int iq_word_w(input int iq_w);
        return 2 * iq_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iq_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : iq_sync_fifo
// Description : Single-clock FIFO with registered read data and occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module iq_sync_fifo
    import dot11_tx_pkg::*;
#(
    parameter int WIDTH = C_IQ_WORD_W,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int                C_AW       = $clog2(DEPTH);
    localparam logic [C_AW:0]     C_FULL_LVL = DEPTH[C_AW:0];
    localparam logic [C_AW:0]     C_LVL_ONE  = 1;
    localparam logic [C_AW-1:0]   C_PTR_ONE  = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_AW-1:0]  r_wr_ptr;
    logic [C_AW-1:0]  r_rd_ptr;
    logic [C_AW:0]    r_level;
    logic [WIDTH-1:0] r_dout;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_level == C_FULL_LVL);
    assign o_empty = (r_level == '0);
    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;
    assign o_level = r_level;
    assign o_dout  = r_dout;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_dout   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
                r_dout   <= r_mem[r_rd_ptr];
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + C_LVL_ONE;
                2'b01:   r_level <= r_level - C_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dot11_tx_iq_pacer.sv
`default_nettype none
// ============================================================================
// Module      : dot11_tx_iq_pacer
// Description : Buffers the dot11_tx IQ stream and emits one sample every
//               CLK_DIV clocks, flagging underrun and end of packet.
// Revision    : 1.0 - initial release
// ============================================================================
module dot11_tx_iq_pacer
    import dot11_tx_pkg::*;
#(
    parameter int DEPTH        = 64,
    parameter int CLK_DIV      = 10,
    parameter int START_THRESH = 16,
    parameter int IQ_W         = C_IQ_W
) (
    input  logic                    clk,
    input  logic                    phy_tx_arest,
    input  logic                    phy_tx_done,
    input  logic                    s_iq_valid,
    output logic                    s_iq_ready,
    input  logic signed [IQ_W-1:0]  s_i,
    input  logic signed [IQ_W-1:0]  s_q,
    output logic                    m_iq_valid,
    output logic signed [IQ_W-1:0]  m_i,
    output logic signed [IQ_W-1:0]  m_q,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    underrun,
    output logic                    tx_iq_done
);
    localparam int                   C_WORD_W   = iq_word_w(IQ_W);
    localparam int                   C_LVL_W    = $clog2(DEPTH) + 1;
    localparam int                   C_DIV_W    = $clog2(CLK_DIV);
    localparam logic [C_DIV_W-1:0]   C_DIV_LAST = C_DIV_W'(CLK_DIV - 1);
    localparam logic [C_DIV_W-1:0]   C_DIV_ONE  = 1;
    localparam logic [C_LVL_W-1:0]   C_THRESH   = C_LVL_W'(START_THRESH);

    pacer_state_t        r_state;
    pacer_state_t        w_state_nxt;
    logic [C_DIV_W-1:0]  r_div;
    logic                r_done_seen;
    logic                r_underrun;
    logic                r_zero_out;
    logic                r_out_valid;
    logic                r_tx_done;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_strobe;
    logic                w_last_strobe;
    logic                w_fill_strobe;
    logic [C_WORD_W-1:0] w_dout;

    assign s_iq_ready    = !w_full;
    assign w_push        = s_iq_valid && s_iq_ready;
    assign w_strobe      = (r_state == ST_STREAM) && (r_div == C_DIV_LAST);
    assign w_pop         = w_strobe && !w_empty;
    assign w_last_strobe = w_strobe && w_empty && r_done_seen;
    assign w_fill_strobe = w_strobe && w_empty && !r_done_seen;

    iq_sync_fifo #(
        .WIDTH (C_WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (phy_tx_arest),
        .i_push  (w_push),
        .i_din   ({s_i, s_q}),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_level (fifo_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge phy_tx_arest) begin
        if (phy_tx_arest) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_push) w_state_nxt = ST_PREFILL;
            ST_PREFILL: if ((fifo_level >= C_THRESH) || r_done_seen) w_state_nxt = ST_STREAM;
            ST_STREAM:  if (w_last_strobe) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Divider idles at zero outside STREAM, so entry always starts a full period.
    always_ff @(posedge clk or posedge phy_tx_arest) begin
        if (phy_tx_arest) begin
            r_div       <= '0;
            r_done_seen <= 1'b0;
            r_underrun  <= 1'b0;
            r_zero_out  <= 1'b0;
            r_out_valid <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            r_out_valid <= w_strobe && !w_last_strobe;
            r_tx_done   <= w_last_strobe;

            if ((r_state != ST_STREAM) || (r_div == C_DIV_LAST)) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + C_DIV_ONE;
            end

            if (w_state_nxt == ST_IDLE) begin
                r_done_seen <= 1'b0;
            end else if (phy_tx_done && (r_state != ST_IDLE)) begin
                r_done_seen <= 1'b1;
            end

            if ((r_state == ST_IDLE) && w_push) begin
                r_underrun <= 1'b0;
            end else if (w_fill_strobe) begin
                r_underrun <= 1'b1;
            end

            if (w_pop) begin
                r_zero_out <= 1'b0;
            end else if (w_fill_strobe) begin
                r_zero_out <= 1'b1;
            end
        end
    end

    // The FIFO read register holds the last popped word; a fill strobe masks it to zero.
    assign m_i        = r_zero_out ? '0 : w_dout[C_WORD_W-1:IQ_W];
    assign m_q        = r_zero_out ? '0 : w_dout[IQ_W-1:0];
    assign m_iq_valid = r_out_valid;
    assign underrun   = r_underrun;
    assign tx_iq_done = r_tx_done;

endmodule
`default_nettype wire

// File: tb/tb_dot11_tx_iq_pacer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dot11_tx_iq_pacer
// Description : Self-checking bench for dot11_tx_iq_pacer against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dot11_tx_iq_pacer;
    localparam int DEPTH        = 64;
    localparam int CLK_DIV      = 10;
    localparam int START_THRESH = 16;
    localparam int IQ_W         = 16;

    logic                   clk = 1'b0;
    logic                   phy_tx_arest;
    logic                   phy_tx_done;
    logic                   s_iq_valid;
    logic                   s_iq_ready;
    logic signed [IQ_W-1:0] s_i;
    logic signed [IQ_W-1:0] s_q;
    logic                   m_iq_valid;
    logic signed [IQ_W-1:0] m_i;
    logic signed [IQ_W-1:0] m_q;
    logic [6:0]             fifo_level;
    logic                   underrun;
    logic                   tx_iq_done;

    dot11_tx_iq_pacer #(
        .DEPTH        (DEPTH),
        .CLK_DIV      (CLK_DIV),
        .START_THRESH (START_THRESH),
        .IQ_W         (IQ_W)
    ) dut (
        .clk          (clk),
        .phy_tx_arest (phy_tx_arest),
        .phy_tx_done  (phy_tx_done),
        .s_iq_valid   (s_iq_valid),
        .s_iq_ready   (s_iq_ready),
        .s_i          (s_i),
        .s_q          (s_q),
        .m_iq_valid   (m_iq_valid),
        .m_i          (m_i),
        .m_q          (m_q),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .tx_iq_done   (tx_iq_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: sample queue, packet mode, cycles since stream start.
    logic [31:0]            mq[$];
    int                     m_mode;
    int                     m_cnt;
    bit                     m_dn, m_ur, m_ev, m_ed;
    logic signed [IQ_W-1:0] m_ei, m_eq;

    // Per-packet observations of the DUT.
    int first_push, first_out, last_out, done_cyc, n_done;
    int nxt, zeros, seq_err, spacing_err, max_level, fullpop, prev_level;
    int ur_at_done;

    typedef struct {
        int n_a;
        int gap;
        int n_b;
        bit rst_first;
        int exp_done;
        int exp_ur;
        int exp_max_lvl;
        int exp_fullpop;
        bit chk_lat;
    } vec_t;

    function automatic logic [31:0] pack(input int k);
        logic [15:0] a;
        logic [15:0] b;
        a = 16'(k);
        b = 16'(-k);
        return {a, b};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_mode = 0; m_cnt = 0;
        m_dn = 0; m_ur = 0; m_ev = 0; m_ed = 0;
        m_ei = '0; m_eq = '0;
    endtask

    task automatic model_step(input bit v, input logic [31:0] d, input bit dn);
        int          lvl;
        bit          push;
        bit          strobe;
        int          nmode;
        logic [31:0] w;
        lvl    = mq.size();
        push   = v && (lvl != DEPTH);
        strobe = (m_mode == 2) && ((m_cnt % CLK_DIV) == CLK_DIV - 1);
        nmode  = m_mode;
        m_ev = 0; m_ed = 0;
        if (m_mode == 0 && push) begin
            nmode = 1; m_ur = 0;
        end else if (m_mode == 1 && (lvl >= START_THRESH || m_dn)) begin
            nmode = 2;
        end
        if (strobe) begin
            if (lvl > 0) begin
                w = mq.pop_front();
                m_ev = 1; m_ei = w[31:16]; m_eq = w[15:0];
            end else if (!m_dn) begin
                m_ev = 1; m_ei = '0; m_eq = '0; m_ur = 1;
            end else begin
                m_ed = 1; nmode = 0;
            end
        end
        if (push) mq.push_back(d);
        if (nmode == 0)                m_dn = 0;
        else if (dn && m_mode != 0)    m_dn = 1;
        m_cnt  = (nmode == 2 && m_mode == 2) ? m_cnt + 1 : 0;
        m_mode = nmode;
    endtask

    task automatic clear_stats();
        first_push = -1; first_out = -1; last_out = -1; done_cyc = -1; n_done = 0;
        nxt = 0; zeros = 0; seq_err = 0; spacing_err = 0; max_level = 0; fullpop = 0;
        prev_level = int'(fifo_level); ur_at_done = -1;
    endtask

    task automatic cycle(input bit v, input logic [31:0] d, input bit dn, output bit acc);
        logic [41:0] act;
        logic [41:0] exp;
        s_iq_valid = v; s_i = d[31:16]; s_q = d[15:0]; phy_tx_done = dn;
        #1;
        chk("s_iq_ready", int'(s_iq_ready), int'(mq.size() != DEPTH));
        acc = v && (mq.size() != DEPTH);
        model_step(v, d, dn);
        @(posedge clk);
        #1;
        cyc++;
        act = {m_iq_valid, tx_iq_done, underrun, fifo_level, m_i, m_q};
        exp = {m_ev, m_ed, m_ur, 7'(mq.size()), m_ei, m_eq};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL outputs @cyc %0d: {valid,done,ur,level,i,q} got %h expected %h", cyc, act, exp);
        end
        if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        if (prev_level == DEPTH && int'(fifo_level) == DEPTH - 1) fullpop++;
        prev_level = int'(fifo_level);
        if (m_iq_valid) begin
            if (first_out < 0) first_out = cyc;
            else if (cyc - last_out != CLK_DIV) spacing_err++;
            last_out = cyc;
            if (m_i == nxt && m_q == -nxt) nxt++;
            else if (m_i == 0 && m_q == 0) zeros++;
            else seq_err++;
        end
        if (tx_iq_done) begin
            n_done++; done_cyc = cyc; ur_at_done = int'(underrun);
        end
    endtask

    task automatic push_samples(input int upto, input bit rnd, inout int k);
        bit v;
        bit acc;
        while (k < upto) begin
            v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            cycle(v, pack(k), 1'b0, acc);
            if (acc) begin
                if (first_push < 0) first_push = cyc;
                k++;
            end
        end
    endtask

    task automatic run_packet(input int n_a, input int gap, input int n_b, input bit rnd);
        int k;
        bit acc;
        k = 0;
        clear_stats();
        push_samples(n_a, rnd, k);
        repeat (gap) cycle(1'b0, '0, 1'b0, acc);
        push_samples(n_a + n_b, rnd, k);
        cycle(1'b0, '0, 1'b1, acc);
        for (int t = 0; t < 3000 && n_done == 0; t++) cycle(1'b0, '0, 1'b0, acc);
        if (n_done == 0) chk("tx_iq_done timeout", 0, 1);
        repeat (2 * CLK_DIV) cycle(1'b0, '0, 1'b0, acc);
    endtask

    task automatic reset_midstream();
        int k;
        bit acc;
        k = 0;
        clear_stats();
        for (int t = 0; t < 5000 && nxt < 30; t++) begin
            cycle(1'b1, pack(k), 1'b0, acc);
            if (acc) k++;
        end
        chk("outputs before reset", nxt, 30);
        #2;
        phy_tx_arest = 1'b1;
        s_iq_valid   = 1'b0;
        #1;
        chk("rst m_iq_valid", int'(m_iq_valid), 0);
        chk("rst m_i", int'(m_i), 0);
        chk("rst m_q", int'(m_q), 0);
        chk("rst fifo_level", int'(fifo_level), 0);
        chk("rst tx_iq_done", int'(tx_iq_done), 0);
        chk("rst s_iq_ready", int'(s_iq_ready), 1);
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
        phy_tx_arest = 1'b0;
        n_done = 0;
        repeat (40) cycle(1'b0, '0, 1'b0, acc);
        chk("no tx_iq_done after reset", n_done, 0);
    endtask

    initial begin
        vec_t tbl[5];
        bit   acc;
        int   na, nb, gp;
        tbl[0] = '{100,   0,  0, 1'b0, 1, 0, 64, 1, 1'b1};
        tbl[1] = '{300,   0,  0, 1'b0, 1, 0, 64, 1, 1'b1};
        tbl[2] = '{ 20, 300, 10, 1'b0, 1, 1, 20, 0, 1'b1};
        tbl[3] = '{  5,   0,  0, 1'b0, 1, 0,  5, 0, 1'b0};
        tbl[4] = '{  8,   0,  0, 1'b1, 1, 0,  8, 0, 1'b0};

        phy_tx_arest = 1'b1;
        phy_tx_done  = 1'b0;
        s_iq_valid   = 1'b0;
        s_i = '0;
        s_q = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset m_iq_valid", int'(m_iq_valid), 0);
        chk("reset fifo_level", int'(fifo_level), 0);
        chk("reset underrun", int'(underrun), 0);
        chk("reset tx_iq_done", int'(tx_iq_done), 0);
        chk("reset m_i", int'(m_i), 0);
        chk("reset s_iq_ready", int'(s_iq_ready), 1);
        phy_tx_arest = 1'b0;

        // Done pulses while idle must be ignored.
        cycle(1'b0, '0, 1'b1, acc);
        repeat (5) cycle(1'b0, '0, 1'b0, acc);

        for (int r = 0; r < 5; r++) begin
            if (tbl[r].rst_first) reset_midstream();
            run_packet(tbl[r].n_a, tbl[r].gap, tbl[r].n_b, 1'b0);
            chk($sformatf("row%0d done pulses", r), n_done, tbl[r].exp_done);
            chk($sformatf("row%0d underrun at done", r), ur_at_done, tbl[r].exp_ur);
            chk($sformatf("row%0d samples in order", r), nxt, tbl[r].n_a + tbl[r].n_b);
            chk($sformatf("row%0d zero fills seen", r), int'(zeros > 0), tbl[r].exp_ur);
            chk($sformatf("row%0d sequence errors", r), seq_err, 0);
            chk($sformatf("row%0d spacing errors", r), spacing_err, 0);
            chk($sformatf("row%0d max level", r), max_level, tbl[r].exp_max_lvl);
            chk($sformatf("row%0d full pop seen", r), int'(fullpop > 0), tbl[r].exp_fullpop);
            chk($sformatf("row%0d done after last strobe", r), done_cyc - last_out, CLK_DIV);
            if (tbl[r].chk_lat)
                chk($sformatf("row%0d first output latency", r), first_out - first_push,
                    START_THRESH + CLK_DIV);
        end

        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(1, 6)) cycle(1'b0, '0, 1'($urandom_range(0, 1)), acc);
            na = $urandom_range(1, 120);
            gp = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(50, 250);
            nb = $urandom_range(0, 30);
            run_packet(na, gp, nb, 1'b1);
            chk($sformatf("rnd%0d done pulses", r), n_done, 1);
            chk($sformatf("rnd%0d samples in order", r), nxt, na + nb);
            chk($sformatf("rnd%0d sequence errors", r), seq_err, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
